// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular sharing of one UART serializer among NUM_REQ byte streams.
// ser_start follows the req_ready handshake by 1 cycle; req_ready is held low while ser_busy.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 400,
  parameter int TIMEOUT    = 4000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           ser_data,
  output logic                 ser_start,
  input  logic                 ser_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 aborted
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_END  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ACK_END = CW'(2);

  typedef enum logic [2:0] {IDLE, SEND, ACK, DRAIN, GAP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        owner, owner_nxt;
  logic [IW-1:0]        rr, rr_nxt;
  logic [IW-1:0]        pick, cand;
  logic                 found;
  logic                 hs;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [7:0]           ser_data_nxt;
  logic                 start_q, start_nxt;
  logic                 aborted_nxt;
  logic                 last_q, last_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;

  // First valid requester strictly after the last winner, wrapping.
  always_comb begin
    pick  = rr;
    cand  = rr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(rr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign hs = (state == SEND) && req_valid[owner] && !ser_busy;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[owner] = 1'b1;
  end

  // Registered pulse, masked so nothing can reach the serializer while it is being reset.
  assign ser_start = start_q & ~reset;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_nxt       = rr;
    grant_nxt    = grant;
    ser_data_nxt = ser_data;
    start_nxt    = 1'b0;
    aborted_nxt  = 1'b0;
    last_nxt     = last_q;
    cnt_nxt      = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt       = pick;
          rr_nxt          = pick;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          ser_data_nxt = req_data[{owner, 3'b000} +: 8];
          start_nxt    = 1'b1;
          last_nxt     = req_last[owner];
          cnt_nxt      = '0;
          state_nxt    = ACK;
        end else if (!req_valid[owner]) begin
          if (cnt >= TO_END) begin
            aborted_nxt = 1'b1;
            grant_nxt   = '0;
            cnt_nxt     = '0;
            state_nxt   = GAP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ACK: begin
        // A serializer that never raises busy is treated as having finished the byte.
        if (ser_busy || cnt >= ACK_END) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!ser_busy) begin
          cnt_nxt = '0;
          if (last_q) begin
            grant_nxt = '0;
            state_nxt = GAP;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (cnt >= GAP_END) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr       <= IW'(NUM_REQ - 1);
      grant    <= '0;
      ser_data <= 8'h00;
      start_q  <= 1'b0;
      aborted  <= 1'b0;
      last_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr       <= rr_nxt;
      grant    <= grant_nxt;
      ser_data <= ser_data_nxt;
      start_q  <= start_nxt;
      aborted  <= aborted_nxt;
      last_q   <= last_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural serializer and short TIMEOUT.
module tb_uart_tx_scheduler;

  localparam int N   = 3;
  localparam int GAP = 400;
  localparam int TO  = 200;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     ser_data;
  logic           ser_start;
  logic           ser_busy = 1'b0;
  logic [N-1:0]   grant;
  logic           aborted;

  int vectors = 0;
  int miscompares = 0;

  int   busy_len = 3470;
  bit   stuck = 1'b0;
  int   rem = 0;
  bit   pend = 1'b0;
  int   start_cnt = 0;
  int   abort_cnt = 0;
  int   ready_cnt = 0;
  int   bad_start = 0;
  logic [7:0] last_data = 8'h00;
  logic reset_prev = 1'b0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .ser_data(ser_data), .ser_start(ser_start), .ser_busy(ser_busy),
    .grant(grant), .aborted(aborted)
  );

  // Serializer: busy rises the cycle after ser_start and stays up for busy_len cycles.
  always @(negedge clk) begin
    if (reset) begin
      ser_busy = 1'b0; rem = 0; pend = 1'b0;
    end else if (stuck) begin
      ser_busy = 1'b1;
    end else if (pend) begin
      pend = 1'b0; ser_busy = 1'b1; rem = busy_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) ser_busy = 1'b0;
    end else begin
      ser_busy = 1'b0;
    end
    if (ser_start && !reset) pend = 1'b1;
  end

  always @(negedge clk) begin
    if (ser_start) begin
      start_cnt++;
      last_data = ser_data;
      if (reset || reset_prev) bad_start++;
    end
    if (aborted) abort_cnt++;
    if (req_ready != 0) ready_cnt++;
    reset_prev = reset;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit want_any, input string tag);
    int n = 0;
    while (((grant != 0) != want_any) && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, " wait grant"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic consume(input logic [N-1:0] g, input string tag);
    int n = 0;
    while (((req_ready & g) == 0) && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, " wait ready"}, 32'(n < 20000), 32'd1);
    @(posedge clk);
    tick();
    req_valid = req_valid & ~g;
  endtask

  task automatic serve(output logic [N-1:0] g, input string tag);
    wait_grant(1'b1, tag);
    g = grant;
    consume(g, tag);
    wait_grant(1'b0, tag);
  endtask

  initial begin
    logic [N-1:0] g;
    int n, s0, a0, r0, moved;

    // Reset values
    repeat (2) @(posedge clk);
    tick();
    chk("rst grant", 32'(grant), 32'h0);
    chk("rst ser_start", 32'(ser_start), 32'h0);
    chk("rst ser_data", 32'(ser_data), 32'h00);
    chk("rst aborted", 32'(aborted), 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    reset = 1'b0;

    // Two-byte packet from req0 with full-length byte times
    req_data[7:0] = 8'h41; req_last[0] = 1'b0; req_valid[0] = 1'b1;
    wait_grant(1'b1, "pkt");
    chk("pkt grant", 32'(grant), 32'h1);
    consume(3'b001, "pkt b0");
    chk("pkt b0 starts", start_cnt, 1);
    chk("pkt b0 data", 32'(last_data), 32'h41);
    req_data[7:0] = 8'h42; req_last[0] = 1'b1; req_valid[0] = 1'b1;
    consume(3'b001, "pkt b1");
    chk("pkt b1 starts", start_cnt, 2);
    chk("pkt b1 data", 32'(last_data), 32'h42);
    wait_grant(1'b0, "pkt end");
    chk("pkt end grant", 32'(grant), 32'h0);

    // Re-request immediately: grant returns GAP+1 cycles after it dropped
    req_data[7:0] = 8'h43; req_valid[0] = 1'b1; busy_len = 20;
    n = 0;
    while (grant == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("gap length", n, GAP + 1);
    chk("regrant req0", 32'(grant), 32'h1);
    consume(3'b001, "pkt2");
    chk("pkt2 data", 32'(last_data), 32'h43);
    chk("pkt2 starts", start_cnt, 3);
    wait_grant(1'b0, "pkt2 end");

    // Contention after reset: rr restarts at N-1 so order is 0,1,2
    reset = 1'b1;
    repeat (2) @(posedge clk);
    tick();
    reset = 1'b0;
    req_data = {8'h30, 8'h20, 8'h10}; req_last = 3'b111; req_valid = 3'b111;
    serve(g, "rr0"); chk("rr0 grant", 32'(g), 32'h1); chk("rr0 data", 32'(last_data), 32'h10);
    serve(g, "rr1"); chk("rr1 grant", 32'(g), 32'h2); chk("rr1 data", 32'(last_data), 32'h20);
    serve(g, "rr2"); chk("rr2 grant", 32'(g), 32'h4); chk("rr2 data", 32'(last_data), 32'h30);
    req_data[7:0] = 8'h11; req_valid[0] = 1'b1;
    serve(g, "rr3"); chk("rr3 grant", 32'(g), 32'h1); chk("rr3 data", 32'(last_data), 32'h11);

    // Fairness: req1 keeps requesting, req2 joins once
    req_data[15:8] = 8'h21; req_valid[1] = 1'b1;
    serve(g, "fair0"); chk("fair0 grant", 32'(g), 32'h2);
    req_data[23:16] = 8'h32; req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    serve(g, "fair1"); chk("fair1 grant", 32'(g), 32'h4); chk("fair1 data", 32'(last_data), 32'h32);
    serve(g, "fair2"); chk("fair2 grant", 32'(g), 32'h2); chk("fair2 data", 32'(last_data), 32'h21);

    // Timeout: req2 sends one non-last byte then goes silent
    s0 = start_cnt; a0 = abort_cnt;
    req_data[23:16] = 8'h55; req_last[2] = 1'b0; req_valid[2] = 1'b1;
    wait_grant(1'b1, "to");
    chk("to grant", 32'(grant), 32'h4);
    consume(3'b100, "to");
    n = 0;
    while (abort_cnt == a0 && n < 3000) begin
      tick();
      n++;
    end
    chk("to abort seen", 32'(n < 3000), 32'd1);
    chk("to grant dropped", 32'(grant), 32'h0);
    repeat (700) tick();
    chk("to abort once", abort_cnt - a0, 1);
    chk("to starts", start_cnt - s0, 1);
    chk("to ser_data", 32'(ser_data), 32'h55);
    req_last[2] = 1'b1;

    // Busy hold-off: serializer stuck busy
    stuck = 1'b1;
    tick();
    req_data[7:0] = 8'h77; req_valid[0] = 1'b1;
    wait_grant(1'b1, "hold");
    chk("hold grant", 32'(grant), 32'h1);
    r0 = ready_cnt; s0 = start_cnt; moved = 0;
    repeat (10000) begin
      tick();
      if (ser_data != 8'h55) moved++;
    end
    chk("hold ready", ready_cnt - r0, 0);
    chk("hold starts", start_cnt - s0, 0);
    chk("hold data stable", moved, 0);
    stuck = 1'b0;
    consume(3'b001, "hold rel");
    chk("hold rel data", 32'(last_data), 32'h77);
    chk("hold rel starts", start_cnt - s0, 1);
    wait_grant(1'b0, "hold end");

    // Reset while the serializer is mid-byte
    busy_len = 3470;
    req_data[15:8] = 8'h99; req_valid[1] = 1'b1;
    wait_grant(1'b1, "drn");
    chk("drn grant", 32'(grant), 32'h2);
    consume(3'b010, "drn");
    repeat (50) tick();
    chk("drn busy", 32'(ser_busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    tick();
    chk("drn rst grant", 32'(grant), 32'h0);
    chk("drn rst ser_start", 32'(ser_start), 32'h0);
    chk("drn rst ser_data", 32'(ser_data), 32'h00);
    chk("drn rst aborted", 32'(aborted), 32'h0);
    chk("drn rst ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    tick();
    reset = 1'b0;
    busy_len = 20;
    req_data[7:0] = 8'hA0; req_data[23:16] = 8'hA2; req_valid = 3'b101;
    serve(g, "post rst");
    chk("post rst grant", 32'(g), 32'h1);
    chk("post rst data", 32'(last_data), 32'hA0);
    req_valid = '0;
    chk("start near reset", bad_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
